// File: rtl/countdown_display_pkg.sv
// Shared types and constants for the countdown display:
// BCD nibbles, seven-segment codes and converter states.
package countdown_display_pkg;

    localparam int DIGITS = 3;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

    function automatic logic [6:0] seg_decode(bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/countdown_display_if.sv
// Timer-to-display bundle: time/done in, BCD and segment pins out.
interface countdown_display_if;
    logic [7:0]  time_left;
    logic        done;
    logic [11:0] bcd_out;
    logic        bcd_valid;
    logic [2:0]  an;
    logic [6:0]  seg;

    modport master (
        output time_left, done,
        input  bcd_out, bcd_valid, an, seg
    );

    modport slave (
        input  time_left, done,
        output bcd_out, bcd_valid, an, seg
    );
endinterface

// File: rtl/countdown_display_bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to three BCD digits
// in one load cycle, eight shift cycles and one commit cycle.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  bin_in,
    input  logic        start,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic        busy
);
    import countdown_display_pkg::*;

    conv_state_t state;
    logic [19:0] sr;
    logic [19:0] adj;
    logic [2:0]  iter;

    // add 3 to each BCD nibble >= 5 before the shift
    always_comb begin
        adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[8 + 4*i +: 4] >= 4'd5)
                adj[8 + 4*i +: 4] = sr[8 + 4*i +: 4] + 4'd3;
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sr        <= '0;
            iter      <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sr    <= {12'h000, bin_in};
                        iter  <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sr   <= {adj[18:0], 1'b0};
                    iter <= iter + 3'd1;
                    if (iter == 3'd7)
                        state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    bcd       <= sr[19:8];
                    bcd_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/countdown_display.sv
// Countdown display: change-triggered BCD conversion, 3-digit
// multiplexed scan with leading-zero blanking and done blink.
module countdown_display #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 12500000,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset,
    countdown_display_if.slave bus
);
    import countdown_display_pkg::*;

    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [2:0] AN_INV  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;
    localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [7:0]    last_value;
    logic          primed;
    logic          start;
    logic [11:0]   conv_bcd;
    logic          conv_valid;
    logic          busy;
    logic [11:0]   bcd_q;
    logic          valid_q;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    scan_idx;
    logic [1:0]    idx_n;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic          on_n;
    logic [2:0]    an_n;
    logic [6:0]    seg_n;
    logic [2:0]    an_q;
    logic [6:0]    seg_q;
    bcd_t          digit;
    logic          blank;

    assign start = !busy && (!primed || bus.time_left != last_value);

    bin2bcd_seq u_conv (
        .clk       (clk),
        .reset     (reset),
        .bin_in    (bus.time_left),
        .start     (start),
        .bcd       (conv_bcd),
        .bcd_valid (conv_valid),
        .busy      (busy)
    );

    // display is built from next-cycle index/phase so it moves with them
    always_comb begin
        idx_n = scan_idx;
        if (scan_cnt == SCAN_LAST)
            idx_n = (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
        on_n = 1'b1;
        if (bus.done)
            on_n = (blink_cnt == BLINK_LAST) ? !blink_on : blink_on;
        digit = bcd_q[3:0];
        blank = 1'b0;
        an_n  = 3'b001;
        unique case (1'b1)
            (idx_n == 2'd0): begin
                digit = bcd_q[3:0];
                blank = 1'b0;
                an_n  = 3'b001;
            end
            (idx_n == 2'd1): begin
                digit = bcd_q[7:4];
                blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
                an_n  = 3'b010;
            end
            default: begin
                digit = bcd_q[11:8];
                blank = (bcd_q[11:8] == 4'd0);
                an_n  = 3'b100;
            end
        endcase
        seg_n = seg_decode(digit);
        if (blank || !on_n) begin
            an_n  = 3'b000;
            seg_n = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_value <= '0;
            primed     <= 1'b0;
            bcd_q      <= '0;
            valid_q    <= 1'b0;
            scan_cnt   <= '0;
            scan_idx   <= '0;
            blink_cnt  <= '0;
            blink_on   <= 1'b1;
            an_q       <= 3'b001 ^ AN_INV;
            seg_q      <= SEG_0 ^ SEG_INV;
        end else begin
            if (start) begin
                last_value <= bus.time_left;
                primed     <= 1'b1;
            end
            valid_q <= conv_valid;
            if (conv_valid)
                bcd_q <= conv_bcd;
            scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
            scan_idx <= idx_n;
            if (bus.done)
                blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
            else
                blink_cnt <= '0;
            blink_on <= on_n;
            an_q     <= an_n ^ AN_INV;
            seg_q    <= seg_n ^ SEG_INV;
        end
    end

    assign bus.bcd_out   = bcd_q;
    assign bus.bcd_valid = valid_q;
    assign bus.an        = an_q;
    assign bus.seg       = seg_q;

endmodule

// File: tb/tb_countdown_display.sv
// Directed bench for countdown_display with short scan/blink dividers.
module tb_countdown_display;

    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;

    countdown_display_if bus ();

    countdown_display #(
        .SCAN_DIV       (4),
        .BLINK_DIV      (8),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Align to the first cycle of a units slot, bounded.
    task automatic sync_units(input string tag);
        logic [2:0] prev;
        bit ok;
        ok = 1'b0;
        prev = bus.an;
        for (int i = 0; i < 24 && !ok; i++) begin
            step(1);
            if (bus.an == 3'b001 && prev != 3'b001) ok = 1'b1;
            else prev = bus.an;
        end
        check({tag, "_sync"}, 32'(ok), 32'd1);
    endtask

    // Check one full scan round: units, tens, hundreds, 4 cycles each.
    task automatic check_scan(input string tag,
                              input logic [9:0] u, input logic [9:0] t,
                              input logic [9:0] h);
        logic [9:0] exp;
        sync_units(tag);
        for (int i = 0; i < 12; i++) begin
            exp = (i < 4) ? u : (i < 8) ? t : h;
            check($sformatf("%s_c%0d", tag, i), 32'({bus.an, bus.seg}),
                  32'(exp));
            step(1);
        end
    endtask

    task automatic convert(input string tag, input logic [7:0] v,
                           input logic [11:0] exp);
        bus.time_left = v;
        step(10);
        check({tag, "_early"}, 32'(bus.bcd_valid), 32'd0);
        step(1);
        check({tag, "_valid"}, 32'(bus.bcd_valid), 32'd1);
        check({tag, "_bcd"}, 32'(bus.bcd_out), 32'(exp));
        step(1);
        check({tag, "_pulse"}, 32'(bus.bcd_valid), 32'd0);
    endtask

    initial begin
        bit found;
        int extra;
        reset = 1'b1;
        bus.time_left = 8'd0;
        bus.done = 1'b0;
        step(3);
        check("rst_bcd", 32'(bus.bcd_out), 32'h000);
        check("rst_valid", 32'(bus.bcd_valid), 32'd0);
        check("rst_an", 32'(bus.an), 32'b001);
        check("rst_seg", 32'(bus.seg), 32'h3F);

        reset = 1'b0;
        step(10);
        check("init_early", 32'(bus.bcd_valid), 32'd0);
        step(1);
        check("init_valid", 32'(bus.bcd_valid), 32'd1);
        check("init_bcd", 32'(bus.bcd_out), 32'h000);
        step(1);
        check("init_pulse", 32'(bus.bcd_valid), 32'd0);
        check_scan("zero", {3'b001, 7'h3F}, 10'h000, 10'h000);

        convert("v255", 8'd255, 12'h255);
        check_scan("s255", {3'b001, 7'h6D}, {3'b010, 7'h6D},
                   {3'b100, 7'h5B});

        convert("v7", 8'd7, 12'h007);
        check_scan("s7", {3'b001, 7'h07}, 10'h000, 10'h000);

        convert("v105", 8'd105, 12'h105);
        check_scan("s105", {3'b001, 7'h6D}, {3'b010, 7'h3F},
                   {3'b100, 7'h06});

        bus.time_left = 8'd50;
        step(1);
        bus.time_left = 8'd49;
        step(1);
        bus.time_left = 8'd48;
        step(1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.bcd_valid && bus.bcd_out == 12'h048) found = 1'b1;
            else step(1);
        end
        check("burst_final", 32'(found), 32'd1);
        extra = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            if (bus.bcd_valid) extra++;
        end
        check("burst_quiet", 32'(extra), 32'd0);
        check("burst_bcd", 32'(bus.bcd_out), 32'h048);

        bus.time_left = 8'd255;
        step(12);
        check("pre_blink_bcd", 32'(bus.bcd_out), 32'h255);
        bus.done = 1'b1;
        step(7);
        check("blink_on1", 32'(bus.an != 3'b000), 32'd1);
        step(1);
        check("blink_off1_an", 32'(bus.an), 32'b000);
        check("blink_off1_seg", 32'(bus.seg), 32'h00);
        step(7);
        check("blink_off1_end", 32'(bus.an), 32'b000);
        step(1);
        check("blink_on2", 32'(bus.an != 3'b000), 32'd1);
        step(8);
        check("blink_off2", 32'(bus.an), 32'b000);
        step(2);
        check("blink_off2_mid", 32'(bus.an), 32'b000);
        bus.done = 1'b0;
        step(1);
        check("done_fall_on", 32'(bus.an != 3'b000), 32'd1);

        bus.time_left = 8'd123;
        step(1);
        step(3);
        reset = 1'b1;
        step(1);
        check("mid_rst_bcd", 32'(bus.bcd_out), 32'h000);
        check("mid_rst_valid", 32'(bus.bcd_valid), 32'd0);
        check("mid_rst_an", 32'(bus.an), 32'b001);
        check("mid_rst_seg", 32'(bus.seg), 32'h3F);
        reset = 1'b0;
        step(10);
        check("reconv_early", 32'(bus.bcd_valid), 32'd0);
        step(1);
        check("reconv_valid", 32'(bus.bcd_valid), 32'd1);
        check("reconv_bcd", 32'(bus.bcd_out), 32'h123);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_display.md
Name: countdown_display

Overview:
Downstream consumer of the countdown timer. Takes the timer's 8-bit remaining-time value and its done flag, converts the binary value to three BCD digits with a sequential double-dabble engine, and drives a 3-digit multiplexed seven-segment display. Leading zeros are blanked, and the display blinks while done is high. Sits between the timer and the board's segment/anode pins.

Parameters:
SCAN_DIV, 50000, clk cycles each digit slot is held (≈1 kHz slot rate at 50 MHz).
BLINK_DIV, 12500000, clk cycles per blink half-period while done=1.
SEG_ACTIVE_LOW, 0, 1 inverts seg and an outputs at the output register.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
time_left  input  8  binary remaining time from the timer.
done  input  1  timer-finished flag, level.
bcd_out  output  12  {hundreds,tens,units} BCD of the last converted value.
bcd_valid  output  1  one-cycle pulse when bcd_out updates.
an  output  3  digit enables, one-hot; bit0 = units, bit2 = hundreds.
seg  output  7  segments {g,f,e,d,c,b,a}.

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values (polarity shown for SEG_ACTIVE_LOW=0):
  - bcd_out=12'h000, bcd_valid=0.
  - an=3'b001, seg=7'h3F (shows "0").
  - Converter FSM = IDLE, last_value=0, primed=0, scan index=0, scan counter=0.
  - Blink counter=0, blink phase=ON.
- Converter FSM states: IDLE, SHIFT, COMMIT.
  - IDLE→SHIFT when primed==0 or time_left!=last_value.
  - On that transition: latch time_left into the shift register and into last_value; set primed=1; clear the BCD scratch register.
  - SHIFT: 8 cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1. A 3-bit iteration counter exits to COMMIT after the 8th shift.
  - COMMIT: write bcd_out, pulse bcd_valid for 1 cycle, return to IDLE.
  - Latency: 10 cycles from the IDLE sampling edge to bcd_out valid.
- time_left changes while in SHIFT/COMMIT are ignored. On return to IDLE, the value is compared against last_value, so the final settled value is always converted. Intermediate values may be skipped.
- Scan:
  - The counter counts 0..SCAN_DIV-1. At wrap, the index advances 0→1→2→0.
  - an and seg update on the same edge the index changes.
- Leading-zero blanking:
  - Hundreds slot is blank if hundreds==0.
  - Tens slot is blank if hundreds==0 and tens==0.
  - Units slot is never blank.
  - A blank slot drives an=000 and seg=00 (before polarity inversion).
- Blink:
  - While done=1, the blink counter counts 0..BLINK_DIV-1 and toggles the phase at wrap.
  - In the OFF phase, an=000 and seg=00 for every slot.
  - While done=0, the counter is held at 0 and phase=ON. A rising edge of done therefore always starts with a full ON half-period.
- Segment codes 0-9: 3F,06,5B,4F,66,6D,7D,07,7F,6F. Nibbles >9 cannot occur; decode them to 00.
- SEG_ACTIVE_LOW=1 inverts an and seg after all of the above, including the reset values.
- Reset mid-conversion aborts the conversion: return to IDLE with primed=0, so the current time_left is reconverted on the first cycle after reset.
- Simultaneous done edge and time_left change: the two are independent; both take effect.

Decomposition:
- Shared package:
  - Digit count (3).
  - BCD nibble type.
  - Seven-segment code constants for 0-9 and blank.
  - Converter FSM state encoding.
- One sub-module: bin2bcd_seq.
  - Contains the double-dabble FSM.
  - Ports: clk, reset, bin_in[7:0], start, bcd[11:0], bcd_valid, busy.
- The top holds the change detection, scan, blank, blink and output registers.

Test Plan (SCAN_DIV=4, BLINK_DIV=8, SEG_ACTIVE_LOW=0):
1. Reset held with time_left=0 → bcd_out=000, an=001, seg=3F. After release, one conversion gives bcd_valid pulse with bcd_out=000, and only the units slot is lit.
2. time_left=255 → 10 cycles later bcd_out=12'h255 with a single bcd_valid pulse. Scan gives an=001/seg=6D, an=010/seg=6D, an=100/seg=5B, each held 4 cycles.
3. time_left=7 → bcd_out=007. Units slot shows an=001/seg=07. Tens and hundreds slots show an=000/seg=00.
4. time_left=105 → tens slot shows an=010/seg=3F (zero not blanked because hundreds=1).
5. time_left changes 50→49→48 on consecutive cycles, then holds → final bcd_out=048. No bcd_valid after the 048 pulse while the input is stable.
6. done rises → 8 cycles of normal scan, 8 cycles of an=000, repeating. done falls mid-OFF phase → the next cycle shows the normal scan. Reset asserted 3 cycles into a SHIFT → reset values, then reconversion of the current time_left.
